// File: rtl/qupls_ins_window.sv
// Instruction window builder ahead of the Qupls decoder: buffers parcels and
// presents head + postfix chain. Optional stall counter under QUPLS_INSWIN_PERF_EN.
module qupls_ins_window #(
  parameter int IW    = 48,
  parameter int PCW   = 32,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_ins,
  input  logic [PCW-1:0]  in_pc,
  input  logic            in_pfx,
  input  logic            dec_ready,
  output logic            out_valid,
  output logic            en,
  output logic [6*IW-1:0] out_ins,
  output logic [PCW-1:0]  out_pc,
  output logic [5:0]      out_slot_v,
  output logic            out_orphan
`ifdef QUPLS_INSWIN_PERF_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [IW-1:0]    ins_mem [DEPTH];
  logic [PCW-1:0]   pc_mem  [DEPTH];
  logic [DEPTH-1:0] pfx_mem;

  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic          any, head_pfx, complete, push, run;
  logic [2:0]    chain_len;
  logic [AW:0]   pop_n;
  logic [AW-1:0] idx;

  // Postfix chain scan stops at the first non-postfix entry, at the buffered
  // count, or after five parcels; an orphan head never owns a chain.
  always_comb begin
    any       = (count != '0);
    head_pfx  = any & pfx_mem[head];
    chain_len = '0;
    run       = ~head_pfx;
    idx       = '0;
    for (int unsigned k = 1; k < 6; k++) begin
      idx = head + AW'(k);
      if (run && ((AW+1)'(k) < count) && pfx_mem[idx])
        chain_len = chain_len + 3'd1;
      else
        run = 1'b0;
    end
    pop_n    = (AW+1)'(chain_len) + (AW+1)'(1);
    complete = any & (head_pfx | (chain_len == 3'd5) | (count > pop_n));
  end

  assign in_ready   = rst & (count < (AW+1)'(DEPTH));
  assign push       = in_valid & in_ready & ~flush;
  assign out_valid  = complete & ~flush;
  assign en         = out_valid & dec_ready;
  assign out_pc     = any ? pc_mem[head] : '0;
  assign out_orphan = head_pfx;

  always_comb begin
    out_slot_v = '0;
    out_ins    = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      out_slot_v[k] = any & (3'(k) <= chain_len);
      if (out_slot_v[k])
        out_ins[k*IW +: IW] = ins_mem[head + AW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ins_mem[tail] <= in_ins;
      pc_mem[tail]  <= in_pc;
      pfx_mem[tail] <= in_pfx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + AW'(1);
      if (en)
        head <= head + pop_n[AW-1:0];
      count <= count + (AW+1)'(push) - (en ? pop_n : '0);
    end
  end

`ifdef QUPLS_INSWIN_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (any && !out_valid && !flush && !(&stall_cnt))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
